// File: rtl/dummy_streamer_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO: a packet leaves only after its TLAST beat is stored; first beat out 1 clk after commit.
// S_AXI_TREADY drops when storage is full (never while dropping an oversize packet); M_AXI_* hold while M_AXI_TREADY is low.
module dummy_streamer_pkt_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_TKEEP,
  input  logic                         S_AXI_TVALID,
  output logic                         S_AXI_TREADY,
  input  logic                         S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]      M_AXI_TKEEP,
  output logic                         M_AXI_TVALID,
  input  logic                         M_AXI_TREADY,
  output logic                         M_AXI_TLAST,
  output logic [STORAGE_IDX_WIDTH:0]   pkt_count,
  output logic [7:0]                   drop_cnt
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** STORAGE_IDX_WIDTH;
  localparam int PW    = STORAGE_IDX_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef struct packed {
    logic            last;
    logic [KW-1:0]   keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] used;
  logic [PW-1:0] partial_next;
  logic          full;

  logic          wr_en;
  logic          commit;
  logic          overflow;
  logic          drop_end;
  logic          out_load;
  logic          rd_avail;
  logic          m_last_hs;

  beat_t         mem [DEPTH];
  beat_t         wr_beat;
  beat_t         rd_beat;

  // Occupancy comes only from registered pointers, so a same-cycle read never frees a slot for a write.
  assign used         = wr_ptr_q - rd_ptr_q;
  assign full         = (used == DEPTH_P);
  assign wr_ptr_inc   = wr_ptr_q + PTR_ONE;
  assign partial_next = wr_ptr_inc - wr_commit_q;

  assign commit   = wr_en && S_AXI_TLAST;
  assign overflow = wr_en && !S_AXI_TLAST && (partial_next == DEPTH_P);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WRITE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WRITE: if (overflow) state_d = ST_DROP;
      ST_DROP:  if (drop_end) state_d = ST_WRITE;
      default:  state_d = ST_WRITE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    S_AXI_TREADY = 1'b1;
    wr_en        = 1'b0;
    drop_end     = 1'b0;
    case (state_q)
      ST_WRITE: begin
        S_AXI_TREADY = !full;
        wr_en        = S_AXI_TVALID && !full;
      end
      ST_DROP: begin
        drop_end = S_AXI_TVALID && S_AXI_TLAST;
      end
      default: ;
    endcase
  end

  // Overflow rewinds wr_ptr to the last packet boundary, discarding the partial packet.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    if (wr_en) begin
      if (S_AXI_TLAST) begin
        wr_ptr_d    = wr_ptr_inc;
        wr_commit_d = wr_ptr_inc;
      end else if (overflow) begin
        wr_ptr_d = wr_commit_q;
      end else begin
        wr_ptr_d = wr_ptr_inc;
      end
    end
  end

  assign wr_beat = '{last: S_AXI_TLAST, keep: S_AXI_TKEEP, data: S_AXI_TDATA};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[STORAGE_IDX_WIDTH-1:0]] <= wr_beat;
    end
  end

  assign out_load  = !M_AXI_TVALID || M_AXI_TREADY;
  assign rd_avail  = (rd_ptr_q != wr_commit_q);
  assign rd_ptr_d  = (out_load && rd_avail) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign rd_beat   = mem[rd_ptr_q[STORAGE_IDX_WIDTH-1:0]];
  assign m_last_hs = M_AXI_TVALID && M_AXI_TREADY && M_AXI_TLAST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Output register: a held beat stays put until accepted; data is left as-is when going idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_AXI_TVALID <= 1'b0;
      M_AXI_TLAST  <= 1'b0;
      M_AXI_TKEEP  <= '0;
      M_AXI_TDATA  <= '0;
    end else if (out_load) begin
      if (rd_avail) begin
        M_AXI_TVALID <= 1'b1;
        M_AXI_TLAST  <= rd_beat.last;
        M_AXI_TKEEP  <= rd_beat.keep;
        M_AXI_TDATA  <= rd_beat.data;
      end else begin
        M_AXI_TVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (commit && !m_last_hs) begin
      pkt_count <= pkt_count + PTR_ONE;
    end else if (!commit && m_last_hs) begin
      pkt_count <= pkt_count - PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 8'd0;
    end else if (drop_end && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dummy_streamer_pkt_fifo.sv
// Scoreboard bench: accepted input beats feed a packet-level model; a monitor pops and compares every output handshake.
module tb_dummy_streamer_pkt_fifo;
  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int IW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s_dat;
  logic [KW-1:0] s_keep;
  logic          s_vld;
  logic          s_rdy;
  logic          s_last;
  logic [DW-1:0] m_dat;
  logic [KW-1:0] m_keep;
  logic          m_vld;
  logic          m_rdy;
  logic          m_last;
  logic [IW:0]   pkt_count;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  dummy_streamer_pkt_fifo #(.DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(s_dat), .S_AXI_TKEEP(s_keep), .S_AXI_TVALID(s_vld),
    .S_AXI_TREADY(s_rdy), .S_AXI_TLAST(s_last),
    .M_AXI_TDATA(m_dat), .M_AXI_TKEEP(m_keep), .M_AXI_TVALID(m_vld),
    .M_AXI_TREADY(m_rdy), .M_AXI_TLAST(m_last),
    .pkt_count(pkt_count), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur_pkt[$];
  bit    dropping;
  int    drop_exp;
  int    pkt_exp;
  int    cmp;
  int    mism;
  int    ready_mode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    cmp++;
    if (act !== req) begin
      mism++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Master-ready driver: 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 held off.
  initial begin
    bit [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    m_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_rdy = 1'b1;
        1: m_rdy = 1'($urandom_range(0, 1));
        2: begin m_rdy = pat[k]; k = (k + 1) % 4; end
        default: m_rdy = 1'b0;
      endcase
    end
  end

  // Reference model: whole packets of up to DEPTH beats are forwarded; a longer one is dropped and counted.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        cur_pkt.delete();
        exp_q.delete();
        dropping = 0;
        drop_exp = 0;
        pkt_exp = 0;
      end else if (s_vld && s_rdy) begin
        b = '{last: s_last, keep: s_keep, data: s_dat};
        if (dropping) begin
          if (s_last) begin
            dropping = 0;
            if (drop_exp < 255) drop_exp++;
          end
        end else begin
          cur_pkt.push_back(b);
          if (s_last) begin
            foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
            cur_pkt.delete();
            pkt_exp++;
          end else if (cur_pkt.size() == DEPTH) begin
            dropping = 1;
            cur_pkt.delete();
          end
        end
      end
    end
  end

  // Monitor: counters, ready rules, stall stability, and output beats against the scoreboard.
  initial begin
    beat_t e;
    logic [37:0] held;
    bit stall;
    stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_m_valid", 64'(m_vld), 64'd0);
        chk("rst_m_out", 64'({m_last, m_keep, m_dat}), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        stall = 0;
      end else begin
        chk("pkt_count", 64'(pkt_count), 64'(pkt_exp));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
        if (dropping) chk("tready_in_drop", 64'(s_rdy), 64'd1);
        if (exp_q.size() + cur_pkt.size() < DEPTH) chk("tready_with_space", 64'(s_rdy), 64'd1);
        if (stall) chk("m_stable", 64'({m_vld, m_last, m_keep, m_dat}), 64'(held));
        if (m_vld && exp_q.size() == 0) begin
          cmp++;
          mism++;
          $display("FAIL unexpected_beat: got data %0h, required no valid beat", m_dat);
        end else if (m_vld && m_rdy) begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({m_last, m_keep, m_dat}), 64'(e));
          if (e.last) pkt_exp--;
        end
        stall = m_vld && !m_rdy;
        held = {m_vld, m_last, m_keep, m_dat};
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit acc;
    int n;
    s_vld = 1'b1;
    s_dat = d;
    s_keep = k;
    s_last = l;
    acc = 0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = s_rdy;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      cmp++;
      mism++;
      $display("FAIL send_timeout: got no S_AXI_TREADY in %0d cycles, required acceptance", n);
    end
    s_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        send_beat($urandom, KW'($urandom), i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end else begin
        send_beat(base + DW'(i), '1, i == len - 1);
      end
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_vld) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    cmp++;
    if (n >= 3000) begin
      mism++;
      $display("FAIL %s_drain: %0d beats still pending, required 0", nm, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cmp = 0;
    mism = 0;
    ready_mode = 0;
    s_vld = 1'b0;
    s_dat = '0;
    s_keep = '0;
    s_last = 1'b0;
    dropping = 0;
    drop_exp = 0;
    pkt_exp = 0;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    // T1: latency of a 4-beat packet with the sink always ready.
    for (int i = 0; i < 3; i++) send_beat(DW'(32'h10 + i), '1, 1'b0);
    send_beat(32'h13, '1, 1'b1);
    @(negedge clk);
    chk("t1_valid_at_commit", 64'(m_vld), 64'd0);
    @(negedge clk);
    chk("t1_valid_after_commit", 64'(m_vld), 64'd1);
    chk("t1_first_data", 64'(m_dat), 64'h10);
    @(posedge clk); #1;
    drain("t1");

    // T2: oversize packet dropped, following packet intact.
    send_pkt(20, 32'h100, 0);
    send_pkt(3, 32'hA0, 0);
    drain("t2");
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);

    // T3: exactly DEPTH beats fills storage and still commits.
    send_pkt(DEPTH, 32'h0, 0);
    @(negedge clk);
    chk("t3_full_tready", 64'(s_rdy), 64'd0);
    @(posedge clk); #1;
    drain("t3");
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);

    // T4: stalled sink pattern, order and stability.
    ready_mode = 2;
    send_pkt(8, 32'h40, 0);
    send_pkt(8, 32'h50, 0);
    drain("t4");

    // Sink held off: storage plus output register hold DEPTH+1 one-beat packets.
    ready_mode = 3;
    idle(2);
    for (int i = 0; i < DEPTH + 1; i++) send_beat(DW'(32'h200 + i), KW'(i), 1'b1);
    @(negedge clk);
    chk("hold_full_tready", 64'(s_rdy), 64'd0);
    chk("hold_pkt_count", 64'(pkt_count), 64'(DEPTH + 1));
    @(posedge clk); #1;
    ready_mode = 1;
    drain("hold");

    // T5: back-to-back 1-beat packets overlap commit with output TLAST.
    ready_mode = 0;
    idle(1);
    for (int i = 0; i < 8; i++) send_beat(DW'(32'h300 + i), (i % 2 == 0) ? '0 : '1, 1'b1);
    drain("t5");

    // Random traffic: lengths around the storage size, random keep and sink stalls.
    ready_mode = 1;
    for (int p = 0; p < 250; p++) send_pkt($urandom_range(1, 20), '0, 1);
    drain("rand");

    // drop_cnt saturation.
    ready_mode = 0;
    for (int p = 0; p < 260; p++) send_pkt(DEPTH + 1, 32'h1000, 0);
    drain("sat");
    chk("drop_cnt_saturated", 64'(drop_cnt), 64'd255);

    // T6: reset mid-packet, then a clean 2-beat packet.
    ready_mode = 1;
    send_pkt(3, 32'h700, 0);
    for (int i = 0; i < 5; i++) send_beat(DW'(32'h800 + i), '1, 1'b0);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);
    send_beat(32'h55, '1, 1'b0);
    send_beat(32'h66, '1, 1'b1);
    drain("t6");
    chk("t6_pkt_count", 64'(pkt_count), 64'd0);

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
